// File: rtl/led_chaser_pkg.sv
// Shared mode codes and seed/period helpers for the LED chaser.
// Imported by the chaser top and its prescaler.
package led_chaser_pkg;

    localparam logic [2:0] MODE_SHIFT1   = 3'b000;
    localparam logic [2:0] MODE_FILL     = 3'b001;
    localparam logic [2:0] MODE_CONVERGE = 3'b010;
    localparam logic [2:0] MODE_BOUNCE   = 3'b011;
    localparam logic [2:0] MODE_COUNT    = 3'b100;

    // Modes whose seed is a single lit MSB; every other mode seeds zero.
    function automatic logic seed_msb(input logic [2:0] m);
        return (m == MODE_SHIFT1) || (m == MODE_BOUNCE);
    endfunction

    // Codes above COUNT are reserved and hold q at zero.
    function automatic logic mode_legal(input logic [2:0] m);
        return m <= MODE_COUNT;
    endfunction

    // Ticks per full sequence period for an n-LED chain.
    function automatic longint unsigned period_ticks(
        input logic [2:0] m,
        input int unsigned n
    );
        unique case (m)
            MODE_SHIFT1:   return longint'(n);
            MODE_FILL:     return longint'(n + 1);
            MODE_CONVERGE: return longint'(n / 2 + 1);
            MODE_BOUNCE:   return longint'(2 * n - 2);
            MODE_COUNT:    return 64'd1 << n;
            default:       return 64'd0;
        endcase
    endfunction

endpackage

// File: rtl/led_chaser_param_tick.sv
// Prescaler: pulses tick once every DIV enabled cycles.
// clr restarts the count from zero.
module led_tick_gen
    import led_chaser_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Count enabled cycles, folding back to zero on the tick.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_chaser_param.sv
// Parameterised LED chaser: five patterns stepped by a prescaler.
// Pattern registers and next-state logic live here.
module led_chaser_param
    import led_chaser_pkg::*;
#(
    parameter int N   = 6,
    parameter int DIV = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   mode,
    input  logic         hold,
    input  logic         dir,
    output logic [N-1:0] q,
    output logic         step,
    output logic         wrap
);

    localparam int H = N / 2;

    logic [2:0]   mode_r;
    logic         bdir;
    logic         reload;
    logic         tick;
    logic [N-1:0] q_seed;
    logic [N-1:0] q_nxt;
    logic         bdir_nxt;
    logic         wrap_nxt;
    logic         legal;

    assign reload = (mode != mode_r);
    assign q_seed = seed_msb(mode) ? {1'b1, {(N-1){1'b0}}} : '0;

    led_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (reload && !hold),
        .en    (!hold && !reload),
        .tick  (tick)
    );

    // Next pattern for the registered mode; bdir=1 means moving up.
    always_comb begin
        q_nxt    = '0;
        bdir_nxt = bdir;
        wrap_nxt = 1'b0;
        legal    = mode_legal(mode_r);
        unique case (mode_r)
            MODE_SHIFT1: begin
                if (dir) begin
                    q_nxt    = {q[N-2:0], q[N-1]};
                    wrap_nxt = q[N-1];
                end else begin
                    q_nxt    = {q[0], q[N-1:1]};
                    wrap_nxt = q[0];
                end
            end
            MODE_FILL: begin
                if (&q) begin
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
                end else if (dir) begin
                    q_nxt = {q[N-2:0], 1'b1};
                end else begin
                    q_nxt = {1'b1, q[N-1:1]};
                end
            end
            MODE_CONVERGE: begin
                if (&q) begin
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    q_nxt = {1'b1, q[N-1:H+1], q[H-2:0], 1'b1};
                end
            end
            MODE_BOUNCE: begin
                if (bdir) begin
                    q_nxt = {q[N-2:0], 1'b0};
                    if (q_nxt[N-1]) begin
                        bdir_nxt = 1'b0;
                        wrap_nxt = 1'b1;
                    end
                end else begin
                    q_nxt = {1'b0, q[N-1:1]};
                    if (q_nxt[0]) begin
                        bdir_nxt = 1'b1;
                    end
                end
            end
            MODE_COUNT: begin
                if (dir) begin
                    q_nxt    = q + 1'b1;
                    wrap_nxt = &q;
                end else begin
                    q_nxt    = q - 1'b1;
                    wrap_nxt = (q == '0);
                end
            end
            default: begin
                q_nxt = '0;
            end
        endcase
    end

    // Pattern state: reset > hold > mode reload > tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            q      <= q_seed;
            mode_r <= mode;
            bdir   <= 1'b0;
            step   <= 1'b0;
            wrap   <= 1'b0;
        end else if (hold) begin
            step <= 1'b0;
            wrap <= 1'b0;
        end else if (reload) begin
            q      <= q_seed;
            mode_r <= mode;
            bdir   <= 1'b0;
            step   <= 1'b0;
            wrap   <= 1'b0;
        end else if (tick) begin
            q    <= q_nxt;
            bdir <= bdir_nxt;
            step <= legal;
            wrap <= legal && wrap_nxt;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_chaser_param.sv
// Bench for led_chaser_param: two instances (DIV=1, DIV=3) share
// stimulus; a spec-level model feeds per-instance expectation queues.
module tb_led_chaser_param;

    localparam int N = 6;
    localparam int H = N / 2;
    localparam int MASK = (1 << N) - 1;

    typedef struct packed {
        logic [N-1:0] q;
        logic         step;
        logic         wrap;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   mode = 3'b000;
    logic         hold = 1'b0;
    logic         dir = 1'b0;
    logic [N-1:0] q_a, q_b;
    logic         step_a, step_b, wrap_a, wrap_b;

    int checks = 0;
    int errors = 0;

    exp_t exp_a[$];
    exp_t exp_b[$];

    // Model state per instance: 0 -> DIV=1, 1 -> DIV=3
    int         divs[2] = '{1, 3};
    int         m_pc[2];
    logic [2:0] m_mode[2];
    int         m_q[2];
    int         m_sp[2];
    int         m_bt[2];
    int         m_cc[2];

    always #5 clk = ~clk;

    led_chaser_param #(.N(N), .DIV(1)) u_a (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .hold  (hold),
        .dir   (dir),
        .q     (q_a),
        .step  (step_a),
        .wrap  (wrap_a)
    );

    led_chaser_param #(.N(N), .DIV(3)) u_b (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .hold  (hold),
        .dir   (dir),
        .q     (q_b),
        .step  (step_b),
        .wrap  (wrap_b)
    );

    task automatic load(input int i, input logic [2:0] m);
        m_mode[i] = m;
        m_pc[i]   = 0;
        m_sp[i]   = N - 1;
        m_bt[i]   = 0;
        m_cc[i]   = 0;
        m_q[i]    = (m == 3'd0 || m == 3'd3) ? (1 << (N - 1)) : 0;
    endtask

    task automatic advance(input int i, input logic d, output logic s, output logic w);
        int pos;
        s = 1'b1;
        w = 1'b0;
        case (m_mode[i])
            3'd0: begin
                if (d) begin
                    w = (m_sp[i] == N - 1);
                    m_sp[i] = (m_sp[i] + 1) % N;
                end else begin
                    w = (m_sp[i] == 0);
                    m_sp[i] = (m_sp[i] + N - 1) % N;
                end
                m_q[i] = 1 << m_sp[i];
            end
            3'd1: begin
                if (m_q[i] == MASK) begin
                    m_q[i] = 0;
                    w = 1'b1;
                end else if (d) begin
                    m_q[i] = ((m_q[i] << 1) | 1) & MASK;
                end else begin
                    m_q[i] = (m_q[i] >> 1) | (1 << (N - 1));
                end
            end
            3'd2: begin
                if (m_cc[i] == H) begin
                    m_cc[i] = 0;
                    w = 1'b1;
                end else begin
                    m_cc[i]++;
                end
                m_q[i] = ((((1 << m_cc[i]) - 1) << (N - m_cc[i]))
                         | ((1 << m_cc[i]) - 1)) & MASK;
            end
            3'd3: begin
                m_bt[i] = (m_bt[i] + 1) % (2 * N - 2);
                w = (m_bt[i] == 0);
                pos = (m_bt[i] < N) ? (N - 1 - m_bt[i]) : (m_bt[i] - (N - 1));
                m_q[i] = 1 << pos;
            end
            3'd4: begin
                if (d) begin
                    w = (m_q[i] == MASK);
                    m_q[i] = (m_q[i] + 1) & MASK;
                end else begin
                    w = (m_q[i] == 0);
                    m_q[i] = (m_q[i] + MASK) & MASK;
                end
            end
            default: begin
                m_q[i] = 0;
                s = 1'b0;
            end
        endcase
    endtask

    task automatic model(input int i, input logic r, input logic h,
                         input logic [2:0] m, input logic d, output exp_t e);
        logic s, w;
        s = 1'b0;
        w = 1'b0;
        if (r) begin
            load(i, m);
        end else if (h) begin
            s = 1'b0;
        end else if (m != m_mode[i]) begin
            load(i, m);
        end else if (m_pc[i] == divs[i] - 1) begin
            m_pc[i] = 0;
            advance(i, d, s, w);
        end else begin
            m_pc[i]++;
        end
        e.q    = N'(m_q[i]);
        e.step = s;
        e.wrap = w;
    endtask

    // Drive one cycle of inputs and queue what each instance must show.
    task automatic cyc(input logic r, input logic h, input logic [2:0] m, input logic d);
        exp_t ea, eb;
        @(negedge clk);
        reset = r;
        hold  = h;
        mode  = m;
        dir   = d;
        model(0, r, h, m, d, ea);
        model(1, r, h, m, d, eb);
        exp_a.push_back(ea);
        exp_b.push_back(eb);
    endtask

    // Direct spot check of the DIV=1 instance after the coming edge.
    task automatic dchk(input string nm, input logic [N-1:0] eq,
                        input logic es, input logic ew);
        @(posedge clk);
        #2;
        checks++;
        if (q_a !== eq || step_a !== es || wrap_a !== ew) begin
            errors++;
            $display("FAIL %s: got q=%b step=%b wrap=%b, want q=%b step=%b wrap=%b",
                     nm, q_a, step_a, wrap_a, eq, es, ew);
        end
    endtask

    // Monitor: compare every registered output against the queued model.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_a.size() > 0) begin
                e = exp_a.pop_front();
                checks++;
                if (q_a !== e.q || step_a !== e.step || wrap_a !== e.wrap) begin
                    errors++;
                    $display("FAIL div1 t=%0t: got q=%b step=%b wrap=%b, want q=%b step=%b wrap=%b",
                             $time, q_a, step_a, wrap_a, e.q, e.step, e.wrap);
                end
            end
            if (exp_b.size() > 0) begin
                e = exp_b.pop_front();
                checks++;
                if (q_b !== e.q || step_b !== e.step || wrap_b !== e.wrap) begin
                    errors++;
                    $display("FAIL div3 t=%0t: got q=%b step=%b wrap=%b, want q=%b step=%b wrap=%b",
                             $time, q_b, step_b, wrap_b, e.q, e.step, e.wrap);
                end
            end
        end
    end

    initial begin
        logic [2:0] cm;
        logic       cd;

        // SHIFT1 after reset, full rotation with wrap on return
        cyc(1, 0, 3'd0, 0);
        dchk("shift_reset", 6'b100000, 0, 0);
        repeat (5) cyc(0, 0, 3'd0, 0);
        dchk("shift_lsb", 6'b000001, 1, 0);
        cyc(0, 0, 3'd0, 0);
        dchk("shift_wrap", 6'b100000, 1, 1);

        // FILL from MSB then clear with wrap
        cyc(1, 0, 3'd1, 0);
        repeat (5) cyc(0, 0, 3'd1, 0);
        cyc(0, 0, 3'd1, 0);
        dchk("fill_full", 6'b111111, 1, 0);
        cyc(0, 0, 3'd1, 0);
        dchk("fill_wrap", 6'b000000, 1, 1);

        // CONVERGE
        cyc(1, 0, 3'd2, 1);
        cyc(0, 0, 3'd2, 1);
        dchk("conv_1", 6'b100001, 1, 0);
        repeat (2) cyc(0, 0, 3'd2, 0);
        cyc(0, 0, 3'd2, 1);
        dchk("conv_wrap", 6'b000000, 1, 1);

        // BOUNCE
        cyc(1, 0, 3'd3, 1);
        repeat (5) cyc(0, 0, 3'd3, 1);
        cyc(0, 0, 3'd3, 0);
        dchk("bounce_turn", 6'b000010, 1, 0);
        repeat (3) cyc(0, 0, 3'd3, 0);
        cyc(0, 0, 3'd3, 0);
        dchk("bounce_wrap", 6'b100000, 1, 1);

        // COUNT: both wrap directions, hold freeze, DIV=3 cadence
        cyc(1, 0, 3'd4, 0);
        cyc(0, 0, 3'd4, 0);
        dchk("count_down_wrap", 6'b111111, 1, 1);
        cyc(0, 0, 3'd4, 1);
        dchk("count_up_wrap", 6'b000000, 1, 1);
        repeat (4) cyc(0, 0, 3'd4, 1);
        repeat (5) cyc(0, 1, 3'd4, 1);
        repeat (7) cyc(0, 0, 3'd4, 1);

        // Mode change reload, reserved code, change during hold
        cyc(1, 0, 3'd1, 0);
        repeat (3) cyc(0, 0, 3'd1, 0);
        cyc(0, 0, 3'd0, 0);
        dchk("reload_shift", 6'b100000, 0, 0);
        cyc(0, 0, 3'd6, 0);
        dchk("reserved", 6'b000000, 0, 0);
        cyc(0, 0, 3'd6, 1);
        dchk("reserved_tick", 6'b000000, 0, 0);
        repeat (3) cyc(0, 1, 3'd3, 0);
        cyc(0, 0, 3'd3, 0);
        dchk("hold_then_reload", 6'b100000, 0, 0);

        // Randomised traffic
        cm = 3'd0;
        cd = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 24) == 0) cm = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) cd = ~cd;
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), cm, cd);
        end

        @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_chaser_param.md
LED_CHASER_PARAM -- requirements
Module: led_chaser_param

Interface
REQ-001 The block SHALL have parameter N, default 6, giving the LED count; legal values are even numbers from 4 to 32.
REQ-002 The block SHALL have parameter DIV, default 1, giving clock cycles per pattern step; legal values are 1 to 2^24.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port mode, input, 3 bits: pattern select (codes in REQ-012 to REQ-017).
REQ-006 Port hold, input, 1 bit: synchronous freeze.
REQ-007 Port dir, input, 1 bit: direction; 0 = toward LSB or count down, 1 = toward MSB or count up.
REQ-008 Port q, output, N bits: LED pattern, registered.
REQ-009 Port step, output, 1 bit: one-cycle pulse on each cycle in which q advanced.
REQ-010 Port wrap, output, 1 bit: one-cycle pulse coincident with the step that completes a sequence period.

Function
REQ-011 A tick SHALL occur when the prescale counter (0..DIV-1) equals DIV-1; the counter then returns to 0; DIV=1 SHALL tick every cycle.
REQ-012 SHIFT1 (000), seed bit N-1 one-hot: on each tick q SHALL rotate one position (dir=0 toward LSB, dir=1 toward MSB); wrap SHALL pulse when the lit bit moves end-to-end.
REQ-013 FILL (001), seed all zeros: on each tick a 1 SHALL shift in from the MSB (dir=0) or the LSB (dir=1); the tick after all-ones SHALL give all zeros, with wrap asserted.
REQ-014 CONVERGE (010), seed all zeros: on each tick the upper half SHALL shift a 1 in from the MSB toward the centre and the lower half SHALL shift a 1 in from the LSB toward the centre; all-ones SHALL go to zeros with wrap asserted; dir is ignored.
REQ-015 BOUNCE (011), seed bit N-1 with internal direction toward LSB: a single lit bit SHALL move one position per tick and reverse at bit 0 and bit N-1 without repeating an end position; the period is 2N-2 ticks; wrap SHALL pulse on arrival at bit N-1; dir is ignored.
REQ-016 COUNT (100), seed zero: on each tick q SHALL decrement (dir=0) or increment (dir=1) modulo 2^N; wrap SHALL pulse on 0 to all-ones (dir=0) or all-ones to 0 (dir=1).
REQ-017 Codes 101 to 111 are reserved: q SHALL be forced to zero and step and wrap SHALL stay 0.
REQ-018 A change of dir SHALL take effect on the next tick without a reload.
REQ-019 When mode differs from the registered mode, the next cycle SHALL load the new mode's seed, register the new mode, clear the prescaler and internal bounce direction, and keep step and wrap at 0.
REQ-020 While hold=1, q, the prescaler, the registered mode and the bounce direction SHALL be frozen and step and wrap SHALL be 0; a mode change seen during hold SHALL be applied on the first cycle after hold is released.
REQ-021 Priority SHALL be reset > hold > mode reload > tick.

Reset
REQ-022 On reset, q SHALL load the seed of the current mode input, the registered mode SHALL equal mode, the prescaler SHALL be 0, step and wrap SHALL be 0, and the bounce direction SHALL be toward LSB.
REQ-023 After reset deasserts, the first step SHALL occur DIV cycles later.
REQ-024 No initial blocks, and no asynchronous set or clear on any register, SHALL be used.

Structure
REQ-025 Mode codes and the seed/period helper constants SHALL reside in package led_chaser_pkg.
REQ-026 The prescaler SHALL be a sub-module led_tick_gen (parameter DIV; inputs clk, reset, clr, en; output tick).
REQ-027 The pattern registers and next-state logic SHALL live in led_chaser_param.

Verification (N=6 unless stated)
REQ-028 SHIFT1, DIV=1, dir=0, after reset: q = 100000, then 010000 through 000001, then 100000, with wrap on that last step only.
REQ-029 FILL, dir=0: q = 000000, then 100000, 110000, 111000, 111100, 111110, 111111, then 000000 with wrap on that step.
REQ-030 CONVERGE: q = 000000, then 100001, 110011, 111111, then 000000 with wrap on that step.
REQ-031 BOUNCE: q = 100000, then stepping down to 000001, then 000010, and back to 100000 after 10 ticks total, with wrap on that tick.
REQ-032 COUNT, DIV=3: step SHALL pulse every 3 cycles; with hold=1 for 5 cycles, q stays constant and step=0; dir=1 from 111111 gives 000000 with wrap.
REQ-033 Mode change: FILL at 111000, then mode set to SHIFT1, SHALL give q = 100000 on the next cycle with step=0; mode=110 SHALL give q = 000000.
